// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// The producer/consumer side uses master; the adder uses slave.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, carry held in a register.
// Subtraction is A + ~B + ~borrow_in, so carry_out=1 means no borrow.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             co_q, ov_q;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             accept, last;

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CW'(N - 1));

    // Operands shift right so the active chunk always sits in the low CHUNK bits.
    assign c[0] = cy;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fa_cell u_fa (.a(a_q[i]), .b(b_q[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end

    if (CHUNK == WIDTH) begin : g_one_chunk
        assign a_sh   = '0;
        assign b_sh   = '0;
        assign sum_sh = s;
    end else begin : g_multi_chunk
        assign a_sh   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_sh   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        assign sum_sh = {s, sum_q[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            cy    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q <= bus.a;
                    b_q <= bus.sub ? ~bus.b : bus.b;
                    cy  <= bus.c_in ^ bus.sub;
                    cnt <= '0;
                end
                RUN: begin
                    a_q   <= a_sh;
                    b_q   <= b_sh;
                    sum_q <= sum_sh;
                    cy    <= c[CHUNK];
                    if (last) begin
                        co_q <= c[CHUNK];
                        ov_q <= c[CHUNK] ^ c[CHUNK-1];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Multi-cycle parametrised adder/subtractor built from the team's full-adder cell. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, and propagates carry between chunks in a register. It sits between producer and consumer logic through valid/ready handshakes on input and output. It adds subtract mode, signed overflow detection and flow control, which the single-bit cell lacks.

Parameters:
WIDTH, 16, operand and result width in bits.
CHUNK, 4, bits processed per cycle. Must divide WIDTH. Legal range 1..WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
clk  in  1  sole clock; every register updates on its rising edge.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  operand set offered.
in_ready  out  1  block can accept operands.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
c_in  in  1  carry-in; acts as borrow-in when sub=1.
sub  in  1  0: A+B+c_in; 1: A-B-c_in.
out_valid  out  1  result available.
out_ready  in  1  consumer takes result.
sum  out  WIDTH  result, modulo 2^WIDTH.
carry_out  out  1  raw carry out of the MSB. With sub=1, a value of 1 means no borrow.
overflow  out  1  signed (two's-complement) overflow.

Behaviour:
- One clock; reset is synchronous and active-low: while rst_n=0 at a rising edge, state becomes IDLE and the chunk counter and carry register clear. out_valid, sum, carry_out and overflow reset to 0. in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- FSM states are IDLE, RUN and DONE. in_ready = (state==IDLE).
- IDLE:
  - An edge with in_valid&in_ready captures the operands. A is stored as is. B is stored as sub ? ~b : b. The carry register loads c_in ^ sub. The counter is set to 0 and the state moves to RUN.
  - Inputs are sampled only at this accept edge.
- RUN, each cycle:
  - Add chunk k of A, chunk k of stored B and the carry register using CHUNK chained full-adder cells.
  - Write the CHUNK result bits into sum chunk k, either by LSB-first shift or by indexed write.
  - Update the carry register and increment k.
- On the edge that processes chunk N-1:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - State moves to DONE and out_valid = 1.
- Latency: an accept at edge T gives out_valid=1 after edge T+N. With CHUNK=WIDTH, N=1. With CHUNK=1, N=WIDTH.
- DONE:
  - sum, carry_out and overflow hold stable while out_valid=1 and out_ready=0, for an unbounded time.
  - The edge with out_valid&out_ready completes the transfer: out_valid goes to 0 and the state goes to IDLE. in_ready rises in the next cycle; there is no same-cycle turnaround, so peak throughput is one operation per N+2 cycles.
  - sum, carry_out and overflow keep their last value after the transfer; only out_valid qualifies them.
- in_valid asserted during RUN or DONE is ignored and does not alter the operation in flight.
- out_ready asserted outside DONE has no effect.
- Counter width is max(1, clog2(N)). The counter never wraps mid-operation.
- Reset during RUN or DONE aborts the operation; no partial result is presented.
- X on a, b, c_in or sub outside the accept edge must not propagate.

Test Plan:
1. WIDTH=16, CHUNK=4. a=0x1234, b=0x0FFF, c_in=0, sub=0 -> sum=0x2233, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, add -> sum=0x0000, carry_out=1, overflow=0 (carry ripples through all chunks). a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, c_in=0 -> sum=0xFFFE, carry_out=0, overflow=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
   - a=0x0005, b=0x0002, sub=1, c_in=1 -> sum=0x0002, carry_out=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> outputs stay stable and in_ready=0. Raise out_ready -> one transfer, then in_ready=1 next cycle and the pending operands are accepted.
5. Reset after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 after release. The next operation (0x00FF+0x0001) yields 0x0100 with no residue from the aborted carry.
6. Parameter sweep CHUNK in {1, 16, 8} with randomised a, b, c_in, sub (1000 ops each, random out_ready) -> matches the reference model {carry_out, sum} = a + (sub?~b:b) + (c_in^sub). Latency = WIDTH/CHUNK.
